uart_rx_mux: RTL

Multi-channel receive arbiter. It shares one downstream byte write port (FIFO-style `data_in`/`data_in_wait`/`data_in_write`) among NCH UART receivers. Each channel's `uart_rx` output goes into a one-byte holding register. A round-robin scheduler drains the holding registers into the shared port and tags each byte with its channel number. Per-channel overrun and framing-error counters are kept for software/debug.

---
 rtl/uart_rx_mux_pkg.sv | 23 ++
 rtl/uart_rr_arbiter.sv | 26 ++
 rtl/uart_rx_mux.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_mux_pkg.sv
// Shared definitions for the uart_* receive blocks: FSM encoding and the
// channel-id width helper.
package uart_rx_mux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } mux_state_t;

    // Width needed to index n items; at least 1 so a 1-channel id stays legal.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester found when
// searching upward from last_grant+1, wrapping at NCH.
module uart_rr_arbiter
    import uart_rx_mux_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CW-1:0]  i_last_grant,
    output logic [CW-1:0]  o_gnt_idx,
    output logic           o_gnt_any
);

    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            if (!o_gnt_any && i_req[(int'(i_last_grant) + k) % NCH]) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = CW'((int'(i_last_grant) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/uart_rx_mux.sv
// Shares one downstream byte write port among NCH UART receivers, with a
// one-byte holding register per channel and per-channel saturating counters.
//
// Handshake: data_in/data_in_chan are valid whenever the FSM is in WRITE; a
// byte is taken on every cycle data_in_write=1, which only happens while
// data_in_wait=0. A grant is never withdrawn while waiting.
module uart_rx_mux
    import uart_rx_mux_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 8,
    localparam int CW    = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*8-1:0]     rx_data,
    input  logic [NCH-1:0]       rx_data_ready,
    input  logic [NCH-1:0]       rx_error,
    output logic [7:0]           data_in,
    output logic [CW-1:0]        data_in_chan,
    input  logic                 data_in_wait,
    output logic                 data_in_write,
    input  logic                 clr_counts,
    output logic [NCH*CNT_W-1:0] ovr_count,
    output logic [NCH*CNT_W-1:0] err_count,
    output logic                 dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mux_state_t       r_state;
    mux_state_t       w_state_nxt;
    logic             w_write;
    logic             w_load;
    logic [NCH-1:0]   r_valid;
    logic [7:0]       r_hold [NCH];
    logic [CW-1:0]    r_last_grant;
    logic [7:0]       r_data_in;
    logic [CW-1:0]    r_chan;
    logic [CNT_W-1:0] r_ovr [NCH];
    logic [CNT_W-1:0] r_err [NCH];
    logic [CW-1:0]    w_gnt_idx;
    logic             w_gnt_any;
    logic [NCH-1:0]   w_drain;
    logic [NCH-1:0]   w_capture;
    logic [NCH-1:0]   w_ovr_inc;

    uart_rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req        (r_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_idx    (w_gnt_idx),
        .o_gnt_any    (w_gnt_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_write = ~data_in_wait & ~rst;
                if (w_write) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_drain   = '0;
        w_capture = '0;
        w_ovr_inc = '0;
        for (int i = 0; i < NCH; i++) begin
            w_drain[i]   = w_write && (int'(r_chan) == i);
            w_capture[i] = rx_data_ready[i] && !rx_error[i];
            w_ovr_inc[i] = w_capture[i] && r_valid[i] && !w_drain[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in    <= 8'h00;
            r_chan       <= '0;
            r_last_grant <= CW'(NCH - 1);
        end else if (w_load) begin
            r_data_in    <= r_hold[w_gnt_idx];
            r_chan       <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
        end
    end

    // A drain and a capture on the same channel leave valid set with the new byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                r_valid[i] <= 1'b0;
                r_hold[i]  <= 8'h00;
            end else if (w_capture[i] && (!r_valid[i] || w_drain[i])) begin
                r_valid[i] <= 1'b1;
                r_hold[i]  <= rx_data[8*i +: 8];
            end else if (w_drain[i]) begin
                r_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst || clr_counts) begin
                r_ovr[i] <= '0;
                r_err[i] <= '0;
            end else begin
                if (w_ovr_inc[i] && r_ovr[i] != CNT_MAX) begin
                    r_ovr[i] <= r_ovr[i] + 1'b1;
                end
                if (rx_error[i] && r_err[i] != CNT_MAX) begin
                    r_err[i] <= r_err[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ovr_count = '0;
        err_count = '0;
        for (int i = 0; i < NCH; i++) begin
            ovr_count[CNT_W*i +: CNT_W] = r_ovr[i];
            err_count[CNT_W*i +: CNT_W] = r_err[i];
        end
    end

    assign data_in       = r_data_in;
    assign data_in_chan  = r_chan;
    assign data_in_write = w_write;
    assign dbg_state     = r_state;

endmodule
